// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the multi-cycle RV32 sequencer.
//   - state_t    : FSM state encoding (also exported on the debug state port)
//   - CTRL_*     : bit positions inside the decoder's 13-bit control word
//   - PC_SEL_*   : PC source encodings
//   - WB_SEL_*   : register writeback source encodings
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_ERR    = 3'd7
  } state_t;

  localparam int unsigned CTRL_W   = 13;
  localparam int unsigned CTRL_BNE = 12;
  localparam int unsigned CTRL_JAL = 11;
  localparam int unsigned CTRL_JALR = 10;
  localparam int unsigned CTRL_BR  = 9;
  localparam int unsigned CTRL_MRD = 8;
  localparam int unsigned CTRL_MWR = 7;
  localparam int unsigned CTRL_M2R = 6;
  localparam int unsigned CTRL_RW  = 5;

  localparam logic [1:0] PC_SEL_PC4  = 2'd0;
  localparam logic [1:0] PC_SEL_BR   = 2'd1;
  localparam logic [1:0] PC_SEL_JALR = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;
  localparam logic [1:0] WB_SEL_MUL = 3'd3;

endpackage

// File: rtl/mc_wdog.sv
// mc_wdog: wait-cycle watchdog for the sequencer.
// Ports:
//   clk       in  core clock
//   rst       in  asynchronous reset, active-high
//   i_hold    in  FSM is staying in a waiting state this cycle
//   o_expired out wait counter has reached TIMEOUT
// The counter advances while i_hold is high and clears on any other cycle,
// so every state change restarts the count from zero.
module mc_wdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_hold,
  output logic o_expired
);

  localparam int unsigned W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_cnt <= '0;
    else if (i_hold) r_cnt <= r_cnt + W'(1);
    else             r_cnt <= '0;
  end

  assign o_expired = (r_cnt == W'(TIMEOUT));

endmodule

// File: rtl/mc_ctrl_seq.sv
// mc_ctrl_seq: multi-cycle sequencer for the RV32 core.
// Walks FETCH -> DECODE -> EXEC -> [MEM] -> WB around the decoder, ALU,
// multiplier and memories; a watchdog traps hung handshakes into ERR.
// Ports:
//   clk, rst                 core clock, async active-high reset
//   ctrl_signal[12:0]        decoder control word (latched in DECODE)
//   is_mul                   multiply instruction (latched in DECODE)
//   br_zero                  ALU zero flag, sampled in EXEC
//   imem_stall, dmem_stall   memory not-ready
//   mul_done                 multiplier result valid
//   imem_cen, ir_we          instruction fetch request / IR load
//   dmem_cen, dmem_wen       data memory request / write
//   mul_start                one-cycle multiplier start
//   rf_we, pc_we             register file / PC write
//   pc_sel[1:0], wb_sel[1:0] PC source / writeback source
//   state[2:0]               current FSM state (debug)
//   timeout_err              sticky watchdog error (held until rst)
module mc_ctrl_seq
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl_signal,
  input  logic              is_mul,
  input  logic              br_zero,
  input  logic              imem_stall,
  input  logic              dmem_stall,
  input  logic              mul_done,
  output logic              imem_cen,
  output logic              ir_we,
  output logic              dmem_cen,
  output logic              dmem_wen,
  output logic              mul_start,
  output logic              rf_we,
  output logic              pc_we,
  output logic [1:0]        pc_sel,
  output logic [1:0]        wb_sel,
  output logic [2:0]        state,
  output logic              timeout_err
);

  state_t            r_state;
  state_t            w_next;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_mul;
  logic              r_taken;
  logic              r_first;
  logic              w_hold;
  logic              w_expired;
  logic              w_unused_ctrl;

  // ALU-source / ALU-op bits belong to the datapath, not the sequencer.
  assign w_unused_ctrl = ^r_ctrl[4:0];

  mc_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .i_hold    (w_hold),
    .o_expired (w_expired)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; a completing handshake always beats the watchdog.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = ST_FETCH;
      ST_FETCH: begin
        if (!imem_stall)    w_next = ST_DECODE;
        else if (w_expired) w_next = ST_ERR;
      end
      ST_DECODE: w_next = ST_EXEC;
      ST_EXEC: begin
        if (!r_mul || mul_done)
          w_next = (r_ctrl[CTRL_MRD] | r_ctrl[CTRL_MWR]) ? ST_MEM : ST_WB;
        else if (w_expired)
          w_next = ST_ERR;
      end
      ST_MEM: begin
        if (!dmem_stall)    w_next = ST_WB;
        else if (w_expired) w_next = ST_ERR;
      end
      ST_WB:     w_next = ST_FETCH;
      ST_ERR:    w_next = ST_ERR;
      default:   w_next = ST_IDLE;
    endcase
  end

  assign w_hold = (w_next == r_state) &&
                  ((r_state == ST_FETCH) || (r_state == ST_EXEC) ||
                   (r_state == ST_MEM));

  // Instruction fields. EXEC is only entered from DECODE, so r_first marks
  // the first EXEC cycle; r_taken is rewritten every EXEC cycle so the last
  // one wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl  <= '0;
      r_mul   <= 1'b0;
      r_taken <= 1'b0;
      r_first <= 1'b0;
    end else begin
      r_first <= (r_state == ST_DECODE);
      if (r_state == ST_DECODE) begin
        r_ctrl <= ctrl_signal;
        r_mul  <= is_mul;
      end
      if (r_state == ST_EXEC)
        r_taken <= br_zero ^ r_ctrl[CTRL_BNE];
    end
  end

  // Output decode
  always_comb begin
    imem_cen    = 1'b0;
    ir_we       = 1'b0;
    dmem_cen    = 1'b0;
    dmem_wen    = 1'b0;
    mul_start   = 1'b0;
    rf_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = PC_SEL_PC4;
    wb_sel      = WB_SEL_ALU;
    timeout_err = 1'b0;
    case (r_state)
      ST_FETCH: begin
        imem_cen = 1'b1;
        ir_we    = ~imem_stall;
      end
      ST_EXEC:  mul_start = r_mul & r_first;
      ST_MEM: begin
        dmem_cen = 1'b1;
        dmem_wen = r_ctrl[CTRL_MWR];
      end
      ST_WB: begin
        pc_we = 1'b1;
        rf_we = r_ctrl[CTRL_RW];
        if (r_ctrl[CTRL_JALR])
          pc_sel = PC_SEL_JALR;
        else if (r_ctrl[CTRL_JAL] | (r_ctrl[CTRL_BR] & r_taken))
          pc_sel = PC_SEL_BR;
        if (r_mul)
          wb_sel = WB_SEL_MUL;
        else if (r_ctrl[CTRL_JAL] | r_ctrl[CTRL_JALR])
          wb_sel = WB_SEL_PC4;
        else if (r_ctrl[CTRL_M2R])
          wb_sel = WB_SEL_MEM;
      end
      ST_ERR:   timeout_err = 1'b1;
      default: ;
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_mc_ctrl_seq.sv
// tb_mc_ctrl_seq: directed, cycle-by-cycle check of mc_ctrl_seq.
// A default-TIMEOUT instance runs the instruction flows; a TIMEOUT=4
// instance sharing the same inputs is used for the watchdog scenario.
module tb_mc_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] ctrl_signal;
  logic        is_mul, br_zero, imem_stall, dmem_stall, mul_done;

  logic       imem_cen, ir_we, dmem_cen, dmem_wen, mul_start, rf_we, pc_we, timeout_err;
  logic [1:0] pc_sel, wb_sel;
  logic [2:0] state;

  logic       wd_imem_cen, wd_ir_we, wd_dmem_cen, wd_dmem_wen, wd_mul_start;
  logic       wd_rf_we, wd_pc_we, wd_timeout_err;
  logic [1:0] wd_pc_sel, wd_wb_sel;
  logic [2:0] wd_state;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mc_ctrl_seq dut (
    .clk(clk), .rst(rst), .ctrl_signal(ctrl_signal), .is_mul(is_mul),
    .br_zero(br_zero), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .mul_done(mul_done), .imem_cen(imem_cen), .ir_we(ir_we),
    .dmem_cen(dmem_cen), .dmem_wen(dmem_wen), .mul_start(mul_start),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .wb_sel(wb_sel),
    .state(state), .timeout_err(timeout_err)
  );

  mc_ctrl_seq #(.TIMEOUT(4)) dut_wd (
    .clk(clk), .rst(rst), .ctrl_signal(ctrl_signal), .is_mul(is_mul),
    .br_zero(br_zero), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .mul_done(mul_done), .imem_cen(wd_imem_cen), .ir_we(wd_ir_we),
    .dmem_cen(wd_dmem_cen), .dmem_wen(wd_dmem_wen), .mul_start(wd_mul_start),
    .rf_we(wd_rf_we), .pc_we(wd_pc_we), .pc_sel(wd_pc_sel), .wb_sel(wd_wb_sel),
    .state(wd_state), .timeout_err(wd_timeout_err)
  );

  // Observation vector: {timeout_err, state, wb_sel, pc_sel, pc_we, rf_we,
  //                      mul_start, dmem_wen, dmem_cen, ir_we, imem_cen}
  logic [14:0] obs, obs_wd;
  assign obs    = {timeout_err, state, wb_sel, pc_sel, pc_we, rf_we,
                   mul_start, dmem_wen, dmem_cen, ir_we, imem_cen};
  assign obs_wd = {wd_timeout_err, wd_state, wd_wb_sel, wd_pc_sel, wd_pc_we, wd_rf_we,
                   wd_mul_start, wd_dmem_wen, wd_dmem_cen, wd_ir_we, wd_imem_cen};

  function automatic logic [14:0] ev(input logic te, input logic [2:0] st,
                                     input logic [1:0] wbs, input logic [1:0] pcs,
                                     input logic pcwe, input logic rfwe, input logic ms,
                                     input logic dw, input logic dc, input logic ir,
                                     input logic ic);
    return {te, st, wbs, pcs, pcwe, rfwe, ms, dw, dc, ir, ic};
  endfunction

  function automatic logic [14:0] ev_wb(input logic rfwe, input logic [1:0] pcs,
                                        input logic [1:0] wbs);
    return ev(1'b0, 3'd5, wbs, pcs, 1'b1, rfwe, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  logic [14:0] E_IDLE, E_FETCH_GO, E_FETCH_STALL, E_DEC, E_EXEC, E_EXEC_MS;
  logic [14:0] E_MEM_RD, E_MEM_WR, E_ERR;

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [14:0] exp);
    @(negedge clk);
    check(tag, obs, exp);
  endtask

  task automatic cyc_wd(input string tag, input logic [14:0] exp);
    @(negedge clk);
    check(tag, obs_wd, exp);
  endtask

  initial begin
    E_IDLE        = ev(0, 3'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    E_FETCH_GO    = ev(0, 3'd1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 1);
    E_FETCH_STALL = ev(0, 3'd1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1);
    E_DEC         = ev(0, 3'd2, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    E_EXEC        = ev(0, 3'd3, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    E_EXEC_MS     = ev(0, 3'd3, 2'd0, 2'd0, 0, 0, 1, 0, 0, 0, 0);
    E_MEM_RD      = ev(0, 3'd4, 2'd0, 2'd0, 0, 0, 0, 0, 1, 0, 0);
    E_MEM_WR      = ev(0, 3'd4, 2'd0, 2'd0, 0, 0, 0, 1, 1, 0, 0);
    E_ERR         = ev(1, 3'd7, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1; ctrl_signal = '0; is_mul = 1'b0; br_zero = 1'b0;
    imem_stall = 1'b0; dmem_stall = 1'b0; mul_done = 1'b0;

    @(negedge clk);
    check("reset", obs, E_IDLE);
    check("reset_wd", obs_wd, E_IDLE);
    rst = 1'b0;
    #1 check("idle_after_rst", obs, E_IDLE);

    // add: one state per cycle
    ctrl_signal = 13'h0020;
    cyc("add_fetch", E_FETCH_GO);
    cyc("add_dec",   E_DEC);
    cyc("add_exec",  E_EXEC);
    cyc("add_wb",    ev_wb(1'b1, 2'd0, 2'd0));

    // lw with dmem_stall high across three sampling edges -> 4 MEM cycles
    ctrl_signal = 13'h0170;
    cyc("lw_fetch", E_FETCH_GO);
    cyc("lw_dec",   E_DEC);
    cyc("lw_exec",  E_EXEC);
    dmem_stall = 1'b1;
    for (int i = 0; i < 4; i++) cyc($sformatf("lw_mem%0d", i), E_MEM_RD);
    dmem_stall = 1'b0;
    cyc("lw_wb", ev_wb(1'b1, 2'd0, 2'd1));

    // sw
    ctrl_signal = 13'h0090;
    cyc("sw_fetch", E_FETCH_GO);
    cyc("sw_dec",   E_DEC);
    cyc("sw_exec",  E_EXEC);
    cyc("sw_mem",   E_MEM_WR);
    cyc("sw_wb",    ev_wb(1'b0, 2'd0, 2'd0));

    // beq taken, beq not taken, bne taken
    ctrl_signal = 13'h0200; br_zero = 1'b1;
    cyc("beqt_fetch", E_FETCH_GO);
    cyc("beqt_dec",   E_DEC);
    cyc("beqt_exec",  E_EXEC);
    cyc("beqt_wb",    ev_wb(1'b0, 2'd1, 2'd0));
    br_zero = 1'b0;
    cyc("beqn_fetch", E_FETCH_GO);
    cyc("beqn_dec",   E_DEC);
    cyc("beqn_exec",  E_EXEC);
    cyc("beqn_wb",    ev_wb(1'b0, 2'd0, 2'd0));
    ctrl_signal = 13'h1200;
    cyc("bne_fetch", E_FETCH_GO);
    cyc("bne_dec",   E_DEC);
    cyc("bne_exec",  E_EXEC);
    cyc("bne_wb",    ev_wb(1'b0, 2'd1, 2'd0));

    // mul, done on 5th EXEC cycle; mul_start only in the first
    ctrl_signal = 13'h0020; is_mul = 1'b1; mul_done = 1'b0;
    cyc("mul_fetch", E_FETCH_GO);
    cyc("mul_dec",   E_DEC);
    cyc("mul_exec0", E_EXEC_MS);
    for (int i = 1; i < 5; i++) cyc($sformatf("mul_exec%0d", i), E_EXEC);
    mul_done = 1'b1;
    cyc("mul_wb", ev_wb(1'b1, 2'd0, 2'd3));

    // mul with mul_done already high in the first EXEC cycle
    cyc("mulq_fetch", E_FETCH_GO);
    cyc("mulq_dec",   E_DEC);
    cyc("mulq_exec",  E_EXEC_MS);
    cyc("mulq_wb",    ev_wb(1'b1, 2'd0, 2'd3));
    mul_done = 1'b0; is_mul = 1'b0;

    // jalr, jal
    ctrl_signal = 13'h0420;
    cyc("jalr_fetch", E_FETCH_GO);
    cyc("jalr_dec",   E_DEC);
    cyc("jalr_exec",  E_EXEC);
    cyc("jalr_wb",    ev_wb(1'b1, 2'd2, 2'd2));
    ctrl_signal = 13'h0820;
    cyc("jal_fetch", E_FETCH_GO);
    cyc("jal_dec",   E_DEC);
    cyc("jal_exec",  E_EXEC);
    cyc("jal_wb",    ev_wb(1'b1, 2'd1, 2'd2));

    // reset in the middle of a stalled load
    ctrl_signal = 13'h0170; dmem_stall = 1'b1;
    cyc("rlw_fetch", E_FETCH_GO);
    cyc("rlw_dec",   E_DEC);
    cyc("rlw_exec",  E_EXEC);
    cyc("rlw_mem",   E_MEM_RD);
    rst = 1'b1;
    #1 check("rst_mid_instr", obs, E_IDLE);
    cyc("rst_held", E_IDLE);
    rst = 1'b0; dmem_stall = 1'b0;
    cyc("rst_restart_fetch", E_FETCH_GO);

    // watchdog: TIMEOUT=4 instance with imem_stall stuck high
    imem_stall = 1'b1; rst = 1'b1;
    #1 check("wd_reset", obs_wd, E_IDLE);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc_wd($sformatf("wd_fetch%0d", i), E_FETCH_STALL);
    for (int i = 0; i < 3; i++) cyc_wd($sformatf("wd_err%0d", i), E_ERR);
    check("main_no_timeout", obs, E_FETCH_STALL);
    rst = 1'b1;
    #1 check("wd_rst_in_err", obs_wd, E_IDLE);
    @(negedge clk);
    rst = 1'b0; imem_stall = 1'b0;
    cyc_wd("wd_recover_fetch", E_FETCH_GO);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_seq.md
Name: mc_ctrl_seq

Overview:
- Multi-cycle sequencer for the RV32 core.
- Sequences fetch, decode, execute, memory and writeback around the instruction decoder, ALU, multiplier and the instruction/data memories.
- Consumes the decoder's 13-bit control word and produces per-cycle enables, PC/writeback selects and memory strobes.
- Handles memory stalls and multiply completion, and traps hung handshakes with a watchdog.

Parameters:
- TIMEOUT, 255: maximum consecutive wait cycles in any stalled state before entering ERR (counter width = $clog2(TIMEOUT+1)).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-high.
- ctrl_signal  in  13  decoder control word:
  - [12] branch-on-not-zero
  - [11] jal
  - [10] jalr
  - [9] branch
  - [8] memread
  - [7] memwrite
  - [6] memtoreg
  - [5] regwrite
  - [4] alusrc
  - [3:0] aluctrl
- is_mul  in  1  decoded M-extension multiply; valid alongside ctrl_signal.
- br_zero  in  1  ALU zero flag; valid in EXEC.
- imem_stall  in  1  instruction memory not ready.
- dmem_stall  in  1  data memory not ready.
- mul_done  in  1  multiplier result valid (single-cycle pulse or level).
- imem_cen  out  1  instruction memory request.
- ir_we  out  1  load instruction register.
- dmem_cen  out  1  data memory request.
- dmem_wen  out  1  data memory write.
- mul_start  out  1  one-cycle multiplier start pulse.
- rf_we  out  1  register file write.
- pc_we  out  1  PC update.
- pc_sel  out  2  PC source: 0 = pc+4, 1 = branch/jal target, 2 = jalr target.
- wb_sel  out  2  writeback source: 0 = ALU, 1 = dmem, 2 = pc+4, 3 = multiplier.
- state  out  3  current state (debug).
- timeout_err  out  1  sticky watchdog error.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=7. All outputs are Moore-decoded from the state and registered fields.
- Reset (async, rst=1):
  - state=IDLE; ctrl_q, mul_q, taken_q, wait counter and timeout_err all cleared.
  - Every output is 0 (state=0).
  - Reset mid-instruction aborts with no further strobes.
- IDLE: goes to FETCH on the next clock after rst deasserts.
- FETCH:
  - imem_cen=1.
  - If imem_stall=0: ir_we=1 that same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: latch ctrl_q<=ctrl_signal and mul_q<=is_mul, then go to EXEC. Single cycle.
- EXEC:
  - taken_q <= br_zero ^ ctrl_q[12], sampled on the last EXEC cycle.
  - If mul_q: mul_start=1 only on the first EXEC cycle; stay until mul_done=1. A mul_done arriving in that first cycle is accepted.
  - Non-mul instructions take exactly one EXEC cycle.
  - Exit to MEM if ctrl_q[8]|ctrl_q[7], else to WB.
- MEM:
  - dmem_cen=1; dmem_wen=ctrl_q[7].
  - Both are held stable for the whole stall.
  - Exit to WB when dmem_stall=0.
- WB:
  - pc_we=1.
  - rf_we = ctrl_q[5]. For stores and branches, rf_we=0 because ctrl_q[5] is 0 for them.
  - pc_sel = 2 if ctrl_q[10]; 1 if ctrl_q[11] | (ctrl_q[9] & taken_q); else 0.
  - wb_sel = 3 if mul_q; 2 if ctrl_q[11]|ctrl_q[10]; 1 if ctrl_q[6]; else 0.
  - Then go to FETCH.
- Latency: ALU instruction 4 cycles; load/store 5 cycles; mul 4+N cycles (plus stall cycles).
- Watchdog:
  - The wait counter increments each cycle the FSM stays in FETCH, EXEC (mul wait) or MEM.
  - It clears on any state change.
  - When the counter equals TIMEOUT and the state would not advance, go to ERR.
- ERR: timeout_err=1, all enables 0, stays until rst. If the advance condition and TIMEOUT coincide, advancing wins.
- Only one memory strobe (imem_cen or dmem_cen) is ever active per cycle.

Decomposition:
- Shared package (core_pkg):
  - state encoding constants.
  - ctrl_signal bit-index constants (CTRL_JAL=11, CTRL_JALR=10, CTRL_BR=9, CTRL_BNE=12, CTRL_MRD=8, CTRL_MWR=7, CTRL_M2R=6, CTRL_RW=5).
  - pc_sel and wb_sel encodings.
- Sub-module: mc_wdog, the wait counter plus compare, parameterised by TIMEOUT.

Test Plan:
- add (ctrl=0x0020), no stalls -> one state per cycle IDLE→FETCH→DECODE→EXEC→WB→FETCH; WB cycle has rf_we=1, pc_we=1, pc_sel=0, wb_sel=0.
- lw (ctrl=0x0170), dmem_stall high 3 cycles -> MEM held 4 cycles with dmem_cen=1, dmem_wen=0; then WB with rf_we=1, wb_sel=1.
- sw (ctrl=0x0090) then beq (ctrl=0x0200) with br_zero=1:
  - sw: dmem_wen=1 in MEM, rf_we=0 in WB.
  - beq: no MEM state; WB pc_sel=1, rf_we=0.
  - beq with br_zero=0 -> pc_sel=0.
- mul (is_mul=1, ctrl=0x0020), mul_done after 5 cycles -> mul_start high exactly one cycle; WB wb_sel=3. jalr (ctrl=0x0420) -> pc_sel=2, wb_sel=2.
- imem_stall stuck high, TIMEOUT=4 -> ERR after 5 FETCH cycles; timeout_err=1, all enables 0; rst pulse mid-ERR -> IDLE with all outputs 0.
